// File: rtl/sync_fifo_param_if.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_param_if
// Purpose  : Producer/consumer handshake and status bundle for sync_fifo_param.
// Revision : 1.0  initial release
// ============================================================================
interface sync_fifo_param_if #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CW         = $clog2(FIFO_DEPTH + 1)
);
    logic [FIFO_WIDTH-1:0] data_in;
    logic                  wr_en;
    logic                  rd_en;
    logic [FIFO_WIDTH-1:0] data_out;
    logic                  wr_ack;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  almostfull;
    logic                  almostempty;
    logic [CW-1:0]         count;

    // Producer and consumer side of the FIFO
    modport master (
        output data_in, wr_en, rd_en,
        input  data_out, wr_ack, overflow, underflow,
        input  full, empty, almostfull, almostempty, count
    );

    // The FIFO itself
    modport slave (
        input  data_in, wr_en, rd_en,
        output data_out, wr_ack, overflow, underflow,
        output full, empty, almostfull, almostempty, count
    );
endinterface
`default_nettype wire

// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_param
// Purpose  : Single-clock FIFO, any depth >= 2, optional first-word-fall-through.
// Revision : 1.0  initial release
// ============================================================================
module sync_fifo_param #(
    parameter int FIFO_WIDTH    = 16,
    parameter int FIFO_DEPTH    = 8,
    parameter int AFULL_THRESH  = FIFO_DEPTH - 1,
    parameter int AEMPTY_THRESH = 1,
    parameter int FWFT          = 0,
    parameter int CW            = $clog2(FIFO_DEPTH + 1)
) (
    input  wire logic        clk,
    input  wire logic        rst,
    sync_fifo_param_if.slave bus
);

    localparam int                 c_PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_PTR_W-1:0] c_LAST_PTR = c_PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CW-1:0]      c_FULL_CNT = CW'(FIFO_DEPTH);

    logic [FIFO_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_wr_ack;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_acc;
    logic                  w_wr_acc;
    int                    w_count_i;

    // Explicit wrap keeps non-power-of-two depths on the valid index range
    function automatic logic [c_PTR_W-1:0] next_ptr(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign w_full    = (r_count == c_FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_count_i = int'(r_count);

    // A full FIFO still takes a write when a read frees the slot that cycle
    assign w_rd_acc  = bus.rd_en && !w_empty;
    assign w_wr_acc  = bus.wr_en && (!w_full || w_rd_acc);

    always_ff @(posedge clk) begin
        if (!rst && w_wr_acc) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_wr_ack    <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= next_ptr(r_wr_ptr);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= next_ptr(r_rd_ptr);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_wr_ack    <= w_wr_acc;
            r_overflow  <= bus.wr_en && !w_wr_acc;
            r_underflow <= bus.rd_en && w_empty;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is always on the output; a read only advances rd_ptr
            assign bus.data_out = r_mem[r_rd_ptr];
        end else begin : g_std_read
            logic [FIFO_WIDTH-1:0] r_data_out;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_data_out <= '0;
                end else if (w_rd_acc) begin
                    r_data_out <= r_mem[r_rd_ptr];
                end
            end

            assign bus.data_out = r_data_out;
        end
    endgenerate

    assign bus.wr_ack      = r_wr_ack;
    assign bus.overflow    = r_overflow;
    assign bus.underflow   = r_underflow;
    assign bus.full        = w_full;
    assign bus.empty       = w_empty;
    assign bus.almostfull  = (w_count_i >= AFULL_THRESH);
    assign bus.almostempty = (w_count_i <= AEMPTY_THRESH);
    assign bus.count       = r_count;

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_param
// Purpose  : Vector table, hand sequences and random queue model for two FIFO builds.
// Revision : 1.0  initial release
// ============================================================================
module tb_sync_fifo_param;

    localparam int W = 16;
    localparam logic [26:0] c_MASK_ALL    = '1;
    localparam logic [26:0] c_MASK_NODOUT = ~(27'h00FFFF << 7);

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    sync_fifo_param_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(8)) bus_a ();
    sync_fifo_param_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(5)) bus_b ();

    sync_fifo_param #(.FIFO_WIDTH(W), .FIFO_DEPTH(8), .FWFT(0)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (bus_a)
    );

    sync_fifo_param #(.FIFO_WIDTH(W), .FIFO_DEPTH(5), .FWFT(1)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (bus_b)
    );

    typedef struct {
        logic        rst;
        logic        wr;
        logic        rd;
        logic [15:0] din;
        int          cnt;
        logic [15:0] dout;
        logic        ack;
        logic        ovf;
        logic        udf;
    } vec_t;

    vec_t        vecs[$];
    logic [15:0] q_a[$];
    logic [15:0] q_b[$];

    function automatic void add(logic r, logic w, logic rd, logic [15:0] din, int cnt,
                                logic [15:0] dout, logic ack, logic ovf, logic udf);
        vec_t v;
        v.rst = r;   v.wr = w;     v.rd = rd;   v.din = din;
        v.cnt = cnt; v.dout = dout; v.ack = ack; v.ovf = ovf; v.udf = udf;
        vecs.push_back(v);
    endfunction

    // Expected status word; flags follow from occupancy and default thresholds
    function automatic logic [26:0] status(int cnt, logic [15:0] dout, logic ack, logic ovf,
                                           logic udf, int depth);
        return {4'(cnt), dout, ack, ovf, udf,
                (cnt == depth), (cnt == 0), (cnt >= depth - 1), (cnt <= 1)};
    endfunction

    function automatic logic [26:0] got_a();
        return {4'(bus_a.count), bus_a.data_out, bus_a.wr_ack, bus_a.overflow, bus_a.underflow,
                bus_a.full, bus_a.empty, bus_a.almostfull, bus_a.almostempty};
    endfunction

    function automatic logic [26:0] got_b();
        return {4'(bus_b.count), bus_b.data_out, bus_b.wr_ack, bus_b.overflow, bus_b.underflow,
                bus_b.full, bus_b.empty, bus_b.almostfull, bus_b.almostempty};
    endfunction

    task automatic check(input string name, input logic [26:0] got, input logic [26:0] exp,
                         input logic [26:0] mask);
        n_checks++;
        if ((got & mask) !== (exp & mask)) begin
            n_errors++;
            $display("FAIL %s: got %h required %h (cnt|dout|ack,ovf,udf,full,empty,afull,aempty)",
                     name, got & mask, exp & mask);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic r, input logic w, input logic rd, input logic [15:0] d);
        rst_a         = r;
        bus_a.wr_en   = w;
        bus_a.rd_en   = rd;
        bus_a.data_in = d;
    endtask

    task automatic drive_b(input logic r, input logic w, input logic rd, input logic [15:0] d);
        rst_b         = r;
        bus_b.wr_en   = w;
        bus_b.rd_en   = rd;
        bus_b.data_in = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        wr_r [2];
        logic        rd_r [2];
        logic [15:0] din_r [2];
        logic [15:0] mdout_a;
        int          exp_cnt;

        drive_a(1'b1, 1'b0, 1'b0, 16'h0000);
        drive_b(1'b1, 1'b0, 1'b0, 16'h0000);

        // ---- Vector table for the depth-8 registered-read build ----
        add(1, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
        add(0, 0, 0, 16'h0000, 0, 16'h0000, 0, 0, 0);
        for (int i = 1; i <= 8; i++) add(0, 1, 0, 16'(i), i, 16'h0000, 1, 0, 0);
        add(0, 1, 0, 16'h0009, 8, 16'h0000, 0, 1, 0);
        for (int k = 1; k <= 8; k++) add(0, 0, 1, 16'h0000, 8 - k, 16'(k), 0, 0, 0);
        add(0, 0, 1, 16'h0000, 0, 16'h0008, 0, 0, 1);
        add(0, 1, 1, 16'hAAAA, 1, 16'h0008, 1, 0, 1);
        for (int i = 1; i <= 7; i++) add(0, 1, 0, 16'hC000 + 16'(i), 1 + i, 16'h0008, 1, 0, 0);
        add(0, 1, 1, 16'hBBBB, 8, 16'hAAAA, 1, 0, 0);
        for (int k = 1; k <= 7; k++) add(0, 0, 1, 16'h0000, 8 - k, 16'hC000 + 16'(k), 0, 0, 0);
        add(0, 0, 1, 16'h0000, 0, 16'hBBBB, 0, 0, 0);
        for (int i = 1; i <= 5; i++) add(0, 1, 0, 16'hD000 + 16'(i), i, 16'hBBBB, 1, 0, 0);
        add(1, 1, 1, 16'hFFFF, 0, 16'h0000, 0, 0, 0);
        add(0, 1, 0, 16'h1234, 1, 16'h0000, 1, 0, 0);
        add(0, 0, 1, 16'h0000, 0, 16'h1234, 0, 0, 0);

        foreach (vecs[i]) begin
            drive_a(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din);
            tick();
            check($sformatf("vec%0d", i), got_a(),
                  status(vecs[i].cnt, vecs[i].dout, vecs[i].ack, vecs[i].ovf, vecs[i].udf, 8),
                  c_MASK_ALL);
        end
        drive_a(1'b0, 1'b0, 1'b0, 16'h0000);

        // ---- Depth-5 FWFT build: zero-latency reads across pointer wrap ----
        drive_b(1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        check("b_reset", got_b(), status(0, 16'h0000, 0, 0, 0, 5), c_MASK_NODOUT);
        for (int i = 0; i < 3; i++) begin
            drive_b(1'b0, 1'b1, 1'b0, 16'h0100 + 16'(i));
            tick();
            check($sformatf("b_prefill%0d", i), got_b(),
                  status(i + 1, 16'h0100, 1, 0, 0, 5), c_MASK_ALL);
        end
        for (int i = 3; i < 12; i++) begin
            drive_b(1'b0, 1'b1, 1'b1, 16'h0100 + 16'(i));
            tick();
            check($sformatf("b_stream%0d", i), got_b(),
                  status(3, 16'h0100 + 16'(i - 2), 1, 0, 0, 5), c_MASK_ALL);
        end
        for (int k = 0; k < 3; k++) begin
            drive_b(1'b0, 1'b0, 1'b1, 16'h0000);
            tick();
            check($sformatf("b_drain%0d", k), got_b(),
                  status(2 - k, 16'h010A + 16'(k), 0, 0, 0, 5),
                  (k == 2) ? c_MASK_NODOUT : c_MASK_ALL);
        end
        drive_b(1'b0, 1'b0, 1'b1, 16'h0000);
        tick();
        check("b_underflow", got_b(), status(0, 16'h0000, 0, 0, 1, 5), c_MASK_NODOUT);

        // ---- Random traffic on both builds against queue models ----
        drive_a(1'b1, 1'b0, 1'b0, 16'h0000);
        drive_b(1'b1, 1'b0, 1'b0, 16'h0000);
        tick();
        q_a.delete();
        q_b.delete();
        mdout_a = 16'h0000;
        drive_a(1'b0, 1'b0, 1'b0, 16'h0000);
        drive_b(1'b0, 1'b0, 1'b0, 16'h0000);

        for (int cyc = 0; cyc < 400; cyc++) begin
            // Alternate write-heavy and read-heavy phases so both full and empty are reached
            int wr_pct;
            int rd_pct;
            bit rd_ok [2];
            bit wr_ok [2];
            wr_pct = ((cyc / 40) % 2 == 0) ? 75 : 30;
            rd_pct = 105 - wr_pct;
            for (int d = 0; d < 2; d++) begin
                int sz;
                int depth;
                wr_r[d]  = ($urandom_range(0, 99) < wr_pct);
                rd_r[d]  = ($urandom_range(0, 99) < rd_pct);
                din_r[d] = 16'($urandom);
                sz       = (d == 0) ? q_a.size() : q_b.size();
                depth    = (d == 0) ? 8 : 5;
                rd_ok[d] = rd_r[d] && (sz > 0);
                wr_ok[d] = wr_r[d] && ((sz < depth) || rd_ok[d]);
            end
            drive_a(1'b0, wr_r[0], rd_r[0], din_r[0]);
            drive_b(1'b0, wr_r[1], rd_r[1], din_r[1]);
            tick();

            if (rd_ok[0]) mdout_a = q_a.pop_front();
            if (wr_ok[0]) q_a.push_back(din_r[0]);
            if (rd_ok[1]) void'(q_b.pop_front());
            if (wr_ok[1]) q_b.push_back(din_r[1]);

            check($sformatf("rand_a%0d", cyc), got_a(),
                  status(q_a.size(), mdout_a, wr_ok[0], wr_r[0] && !wr_ok[0],
                         rd_r[0] && !rd_ok[0], 8),
                  c_MASK_ALL);
            exp_cnt = q_b.size();
            check($sformatf("rand_b%0d", cyc), got_b(),
                  status(exp_cnt, (exp_cnt > 0) ? q_b[0] : 16'h0000, wr_ok[1],
                         wr_r[1] && !wr_ok[1], rd_r[1] && !rd_ok[1], 5),
                  (exp_cnt > 0) ? c_MASK_ALL : c_MASK_NODOUT);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
